// File: rtl/sdram_client_pkg.sv
// Shared definitions for the SDRAM burst client: FSM states, burst length and
// default write-window bounds.
package sdram_client_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  localparam int unsigned BURST_LEN   = 8;
  localparam logic [19:0] WR_BASE_DEF = 20'h00000;
  localparam logic [19:0] WR_LAST_DEF = 20'hFFFF8;

endpackage

// File: rtl/sdram_burst_client_sample_fifo.sv
// Synchronous sample FIFO. It reports count, full and empty, and shows the
// head word combinationally (zero while empty).
module sample_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when a pop frees a slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sdram_burst_client.sv
// Sample-stream writer and host-read requester on the SDRAM controller user port.
// Optional SDRAM_CLIENT_STAT_EN adds drop_cnt / burst_cnt statistics outputs.
module sdram_burst_client
  import sdram_client_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 20,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] WR_BASE    = ADDR_W'(WR_BASE_DEF),
  parameter logic [ADDR_W-1:0] WR_LAST    = ADDR_W'(WR_LAST_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              wrap,
  output logic [ADDR_W-1:0] wr_adr_cur,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic              rd_busy,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              u_wreq,
  input  logic              u_wack,
  input  logic              u_wr_da_en,
  output logic [ADDR_W-1:0] u_wadr,
  output logic [DATA_W-1:0] u_wr_da,
  output logic              u_rreq,
  input  logic              u_rack,
  output logic [ADDR_W-1:0] u_radr,
  input  logic              u_rd_da_en,
  input  logic [DATA_W-1:0] u_rd_da
`ifdef SDRAM_CLIENT_STAT_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       burst_cnt
`endif
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   u_wadr_q, u_wadr_d;
  logic [ADDR_W-1:0]   u_radr_q, u_radr_d;
  logic                rd_busy_q, rd_busy_d;
  logic                ovf_q, ovf_d;
  logic                wrap_q, wrap_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                u_wreq_q, u_wreq_d;
  logic                u_rreq_q, u_rreq_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [CNT_W-1:0]    fifo_count;
  logic                beats_left, rd_beat, wr_done, rd_done;

  assign beats_left = (beat_q < BEAT_W'(BURST_LEN));
  assign fifo_pop   = (state_q == ST_WR_DATA) && u_wr_da_en && beats_left && !fifo_empty;
  assign rd_beat    = (state_q == ST_RD_DATA) && u_rd_da_en && beats_left;
  assign wr_done    = (state_q == ST_WR_DATA) && !beats_left && !u_wr_da_en;
  assign rd_done    = (state_q == ST_RD_DATA) && !beats_left && !u_rd_da_en;
  assign fifo_push  = s_valid && (!fifo_full || fifo_pop);
  assign drop       = s_valid && fifo_full && !fifo_pop;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (s_data),
    .rdata   (u_wr_da),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Pending host reads win over a ready write burst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_busy_q)                             state_d = ST_RD_REQ;
        else if (fifo_count >= CNT_W'(BURST_LEN))  state_d = ST_WR_REQ;
      end
      ST_WR_REQ:  if (u_wack)  state_d = ST_WR_DATA;
      ST_WR_DATA: if (wr_done) state_d = ST_IDLE;
      ST_RD_REQ:  if (u_rack)  state_d = ST_RD_DATA;
      ST_RD_DATA: if (rd_done) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_d    = beat_q;
    u_wadr_d  = u_wadr_q;
    u_radr_d  = u_radr_q;
    rd_busy_d = rd_busy_q;
    m_valid_d = 1'b0;
    m_data_d  = m_data_q;
    ovf_d     = (ovf_q && !ovf_clr) || drop;
    wrap_d    = wrap_q && !ovf_clr;
    u_wreq_d  = (state_d == ST_WR_REQ);
    u_rreq_d  = (state_d == ST_RD_REQ);

    if (rd_start && !rd_busy_q) begin
      u_radr_d  = rd_adr & ~ADDR_W'(BURST_LEN - 1);
      rd_busy_d = 1'b1;
    end
    if (fifo_pop || rd_beat) beat_d = beat_q + BEAT_W'(1);
    if (rd_beat) begin
      m_valid_d = 1'b1;
      m_data_d  = u_rd_da;
    end
    if (wr_done) begin
      beat_d = '0;
      if (u_wadr_q == WR_LAST) begin
        u_wadr_d = WR_BASE;
        wrap_d   = 1'b1;
      end else begin
        u_wadr_d = u_wadr_q + ADDR_W'(BURST_LEN);
      end
    end
    if (rd_done) begin
      beat_d    = '0;
      rd_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q    <= '0;
      u_wadr_q  <= WR_BASE;
      u_radr_q  <= '0;
      rd_busy_q <= 1'b0;
      ovf_q     <= 1'b0;
      wrap_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      u_wreq_q  <= 1'b0;
      u_rreq_q  <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      u_wadr_q  <= u_wadr_d;
      u_radr_q  <= u_radr_d;
      rd_busy_q <= rd_busy_d;
      ovf_q     <= ovf_d;
      wrap_q    <= wrap_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      u_wreq_q  <= u_wreq_d;
      u_rreq_q  <= u_rreq_d;
    end
  end

  assign ovf        = ovf_q;
  assign wrap       = wrap_q;
  assign wr_adr_cur = u_wadr_q;
  assign u_wadr     = u_wadr_q;
  assign u_radr     = u_radr_q;
  assign rd_busy    = rd_busy_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign u_wreq     = u_wreq_q;
  assign u_rreq     = u_rreq_q;

`ifdef SDRAM_CLIENT_STAT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;

  // Drop counter saturates; burst counter wraps.
  always_comb begin
    drop_cnt_d  = ovf_clr ? 16'h0000 : drop_cnt_q;
    burst_cnt_d = ovf_clr ? 16'h0000 : burst_cnt_q;
    if (drop && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'd1;
    if (wr_done)                          burst_cnt_d = burst_cnt_d + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign burst_cnt = burst_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_burst_client.sv
// Self-checking bench for sdram_burst_client: directed sequences, a vector
// table for FIFO fill/overflow, and a randomized run against a queue model.
module tb_sdram_burst_client;

  localparam int unsigned BL    = 8;
  localparam int unsigned DEPTH = 16;
  localparam logic [19:0] WR_BASE = 20'h00000;
  localparam logic [19:0] WR_LAST = 20'h00008;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_valid, ovf_clr, rd_start, u_wack, u_wr_da_en, u_rack, u_rd_da_en;
  logic [15:0] s_data, u_rd_da;
  logic [19:0] rd_adr;
  logic        ovf, wrap, rd_busy, m_valid, u_wreq, u_rreq;
  logic [15:0] m_data, u_wr_da;
  logic [19:0] wr_adr_cur, u_wadr, u_radr;
`ifdef SDRAM_CLIENT_STAT_EN
  logic [15:0] drop_cnt, burst_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_burst_client #(
    .ADDR_W(20), .DATA_W(16), .FIFO_DEPTH(DEPTH), .WR_BASE(WR_BASE), .WR_LAST(WR_LAST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data), .ovf(ovf),
    .ovf_clr(ovf_clr), .wrap(wrap), .wr_adr_cur(wr_adr_cur), .rd_start(rd_start),
    .rd_adr(rd_adr), .rd_busy(rd_busy), .m_valid(m_valid), .m_data(m_data),
    .u_wreq(u_wreq), .u_wack(u_wack), .u_wr_da_en(u_wr_da_en), .u_wadr(u_wadr),
    .u_wr_da(u_wr_da), .u_rreq(u_rreq), .u_rack(u_rack), .u_radr(u_radr),
    .u_rd_da_en(u_rd_da_en), .u_rd_da(u_rd_da)
`ifdef SDRAM_CLIENT_STAT_EN
    , .drop_cnt(drop_cnt), .burst_cnt(burst_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    s_valid = 0; s_data = 0; ovf_clr = 0; rd_start = 0; rd_adr = 0;
    u_wack = 0; u_wr_da_en = 0; u_rack = 0; u_rd_da_en = 0; u_rd_da = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_reqs"}, {u_wreq, u_rreq, rd_busy, m_valid}, 0);
    chk({tag, "_flags"}, {ovf, wrap}, 0);
    chk({tag, "_wadr"}, u_wadr, WR_BASE);
    chk({tag, "_wadrcur"}, wr_adr_cur, WR_BASE);
    chk({tag, "_radr_mdata"}, {u_radr, m_data}, 0);
    chk({tag, "_wr_da"}, u_wr_da, 0);
  endtask

  task automatic do_reset();
    drive_idle();
    #2 reset_n = 0;
    #3;
    chk_reset_outs("reset");
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic push_n(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_data = first + 16'(i);
      tick();
    end
    s_valid = 0;
  endtask

  task automatic wait_wreq(input string name);
    int k = 0;
    while (!u_wreq && k < 40) begin tick(); k++; end
    chk(name, u_wreq, 1);
  endtask

  task automatic serve_write(input logic [15:0] first, input int n_en, input logic [19:0] exp_adr);
    u_wack = 1; tick(); u_wack = 0;
    chk("wreq_drop_after_ack", u_wreq, 0);
    for (int i = 0; i < n_en; i++) begin
      u_wr_da_en = 1;
      if (i < BL) chk("wr_da", u_wr_da, first + 16'(i));
      tick();
    end
    u_wr_da_en = 0;
    tick();
    chk("wadr_next", u_wadr, exp_adr);
    chk("wr_adr_cur", wr_adr_cur, exp_adr);
  endtask

  typedef struct {
    logic sv;
    logic clr;
    logic exp_ovf;
    logic exp_wreq;
  } vec_t;
  vec_t tbl [21];

  // Randomized-run model state
  logic [15:0] q [$];
  logic [19:0] exp_wadr, exp_radr;
  logic        exp_ovf, exp_wrap, pending, exp_mv, pop, rbeat, wdone, rdone, dropped;
  logic [15:0] exp_md;
  int          cst, wait_cnt, beats, extra;
  int unsigned m_drop, m_burst;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Basic write burst with two surplus enable beats
    push_n(16'h0001, 7);
    tick();
    chk("no_wreq_at_7", u_wreq, 0);
    push_n(16'h0008, 1);
    wait_wreq("t1_wreq");
    serve_write(16'h0001, 10, 20'h00008);
    repeat (5) tick();
    chk("t1_no_extra_req", u_wreq, 0);

    // Reset in the middle of a write burst
    push_n(16'h0009, 8);
    wait_wreq("t6_wreq");
    u_wack = 1; tick(); u_wack = 0;
    for (int i = 0; i < 3; i++) begin
      u_wr_da_en = 1;
      chk("t6_wr_da", u_wr_da, 16'h0009 + 16'(i));
      tick();
    end
    #2 reset_n = 0;
    #1;
    chk_reset_outs("midburst_reset");
    drive_idle();
    tick();
    reset_n = 1;
    push_n(16'h0100, 7);
    repeat (10) tick();
    chk("t6_no_req_7", u_wreq, 0);
    push_n(16'h0107, 1);
    wait_wreq("t6_wreq2");
    serve_write(16'h0100, 8, 20'h00008);

    // Burst from WR_LAST wraps the address
    push_n(16'h0200, 8);
    wait_wreq("t4_wreq");
    serve_write(16'h0200, 8, WR_BASE);
    chk("t4_wrap", wrap, 1);
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("t4_wrap_clr", wrap, 0);

    // Vector table: fill to full, overflow, clear, set-wins-over-clear
    do_reset();
    for (int i = 0; i < 17; i++) tbl[i] = '{1'b1, 1'b0, (i == 16), (i >= 8)};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 21; i++) begin
      s_valid = tbl[i].sv;
      s_data  = (i < 17) ? 16'(i + 1) : 16'hDEAD;
      ovf_clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].exp_ovf);
      chk($sformatf("tbl%0d_wreq", i), u_wreq, tbl[i].exp_wreq);
`ifdef SDRAM_CLIENT_STAT_EN
      if (i == 16) chk("tbl_drop_cnt", drop_cnt, 1);
      if (i == 17) chk("tbl_drop_cnt_clr", drop_cnt, 0);
`endif
    end
    drive_idle();
    serve_write(16'h0001, 8, 20'h00008);
    wait_wreq("t2_wreq2");
    serve_write(16'h0009, 8, WR_BASE);
    repeat (4) tick();
    chk("t2_empty_no_req", u_wreq, 0);

    // Read has priority when it arrives with the 8th sample
    do_reset();
    push_n(16'h0001, 7);
    s_valid = 1; s_data = 16'h0008; rd_start = 1; rd_adr = 20'h00013;
    tick();
    s_valid = 0; rd_start = 0;
    chk("t3_rd_busy", rd_busy, 1);
    chk("t3_radr", u_radr, 20'h00010);
    rd_start = 1; rd_adr = 20'h00040;
    tick();
    rd_start = 0;
    chk("t3_rreq_first", u_rreq, 1);
    chk("t3_no_wreq", u_wreq, 0);
    chk("t5_radr_kept", u_radr, 20'h00010);
    u_rack = 1; tick(); u_rack = 0;
    chk("t3_rreq_drop", u_rreq, 0);
    for (int i = 0; i < 8; i++) begin
      u_rd_da_en = 1; u_rd_da = 16'h00A0 + 16'(i);
      tick();
      chk("t3_m_valid", m_valid, 1);
      chk("t3_m_data", m_data, 16'h00A0 + 16'(i));
    end
    u_rd_da_en = 0;
    tick();
    chk("t3_m_valid_end", m_valid, 0);
    chk("t3_rd_busy_end", rd_busy, 0);
    wait_wreq("t3_wreq_after");
    serve_write(16'h0001, 8, 20'h00008);

    // Randomized run against a queue model acting as the controller
    do_reset();
    q.delete();
    exp_wadr = WR_BASE; exp_radr = 0; exp_ovf = 0; exp_wrap = 0; pending = 0;
    exp_mv = 0; exp_md = 0; cst = 0; wait_cnt = 0; beats = 0; extra = 0;
    m_drop = 0; m_burst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_ovf", ovf, exp_ovf);
      chk("rnd_wrap", wrap, exp_wrap);
      chk("rnd_rd_busy", rd_busy, pending);
      chk("rnd_m_valid", m_valid, exp_mv);
      if (exp_mv) chk("rnd_m_data", m_data, exp_md);

      s_valid = ($urandom % 3) != 0;
      s_data = 16'($urandom);
      ovf_clr = ($urandom % 64) == 0;
      rd_start = ($urandom % 40) == 0;
      rd_adr = 20'($urandom);
      u_wack = 0; u_rack = 0; u_wr_da_en = 0; u_rd_da_en = 0;
      u_rd_da = 16'($urandom);
      pop = 0; rbeat = 0; wdone = 0; rdone = 0; dropped = 0;

      case (cst)
        0: if (u_wreq || u_rreq) begin
          if (wait_cnt == 0) begin
            beats = 0;
            extra = int'($urandom % 3);
            if (u_wreq) begin
              chk("rnd_wadr", u_wadr, exp_wadr);
              u_wack = 1; cst = 1;
            end else begin
              chk("rnd_radr", u_radr, exp_radr);
              u_rack = 1; cst = 2;
            end
            wait_cnt = int'($urandom % 4);
          end else begin
            wait_cnt--;
          end
        end
        1: if (beats < BL) begin
          if (($urandom % 4) != 0) begin
            u_wr_da_en = 1; pop = 1;
            chk("rnd_wr_da", u_wr_da, (q.size() > 0) ? q[0] : 16'hXXXX);
          end
        end else if (extra > 0) begin
          u_wr_da_en = 1; extra--;
        end else begin
          wdone = 1; cst = 0;
        end
        default: if (beats < BL) begin
          if (($urandom % 4) != 0) begin u_rd_da_en = 1; rbeat = 1; end
        end else if (extra > 0) begin
          u_rd_da_en = 1; extra--;
        end else begin
          rdone = 1; cst = 0;
        end
      endcase

      // Model the effect of the coming clock edge
      if (rd_start && !pending) begin
        pending = 1;
        exp_radr = rd_adr & ~20'h7;
      end
      if (rdone) pending = 0;
      exp_mv = rbeat;
      if (rbeat) exp_md = u_rd_da;
      if (pop || rbeat) beats++;
      if (pop && q.size() > 0) void'(q.pop_front());
      if (s_valid) begin
        if (q.size() < DEPTH) q.push_back(s_data);
        else dropped = 1;
      end
      exp_ovf = (exp_ovf && !ovf_clr) || dropped;
      exp_wrap = exp_wrap && !ovf_clr;
      if (ovf_clr) begin m_drop = 0; m_burst = 0; end
      if (dropped && m_drop != 32'hFFFF) m_drop++;
      if (wdone) begin
        m_burst++;
        if (exp_wadr == WR_LAST) begin exp_wadr = WR_BASE; exp_wrap = 1; end
        else exp_wadr = exp_wadr + 20'(BL);
      end
      tick();
    end
    drive_idle();
    chk("rnd_final_wadr_cur", wr_adr_cur, exp_wadr);
`ifdef SDRAM_CLIENT_STAT_EN
    chk("rnd_drop_cnt", drop_cnt, m_drop);
    chk("rnd_burst_cnt", burst_cnt, m_burst & 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
